// File: rtl/pc_redirect_ctrl.sv
// PC redirect sequencer: arbitrates trap/mret/branch/halt and stall sources into PC controls.
// Optional perf counters (Redirect_Cnt, Stall_Cnt) are enabled by defining PC_CTRL_PERF_EN.
module pc_redirect_ctrl #(
  parameter int unsigned       DWIDTH       = 32,
  parameter logic [DWIDTH-1:0] TRAP_VEC     = 32'h0000_0100,
  parameter int unsigned       FLUSH_CYCLES = 2
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core,
  input  logic              Trap_Req,
  input  logic [DWIDTH-1:0] Trap_Pc,
  input  logic              Mret_Req,
  input  logic              Br_Taken,
  input  logic [DWIDTH-1:0] Br_Target,
  input  logic              Halt_Req,
  input  logic              Resume,
  input  logic              Load_Use_Haz,
  input  logic              Imem_Ready,
  output logic              PC_Sel,
  output logic              Stall,
  output logic              Flush,
  output logic [DWIDTH-1:0] Program_Count_Imm,
  output logic              Flush_Pipe,
  output logic [DWIDTH-1:0] Epc,
  output logic              Halted
`ifdef PC_CTRL_PERF_EN
  ,
  output logic [31:0]       Redirect_Cnt,
  output logic [31:0]       Stall_Cnt
`endif
);

  typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

  localparam logic [2:0] DrainInit = 3'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DWIDTH-1:0] epc_q, epc_d;

  logic              pc_sel, stall, flush, flush_pipe, redirect;
  logic [DWIDTH-1:0] pc_imm;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    epc_d      = epc_q;
    pc_sel     = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    flush_pipe = 1'b0;
    redirect   = 1'b0;
    pc_imm     = '0;
    unique case (state_q)
      StRun: begin
        if (Trap_Req) begin
          flush    = 1'b1;
          pc_imm   = TRAP_VEC;
          epc_d    = Trap_Pc;
          redirect = 1'b1;
        end else if (Mret_Req) begin
          flush    = 1'b1;
          pc_imm   = epc_q;
          redirect = 1'b1;
        end else if (Br_Taken) begin
          pc_sel   = 1'b1;
          pc_imm   = Br_Target;
          redirect = 1'b1;
        end else if (Halt_Req) begin
          stall   = 1'b1;
          state_d = StHalt;
        end else begin
          stall = Load_Use_Haz | ~Imem_Ready;
        end
        // A redirect overrides every stall source; the squash window starts now.
        if (redirect) begin
          flush_pipe = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = StDrain;
            cnt_d   = DrainInit;
          end
        end
      end
      StDrain: begin
        flush_pipe = 1'b1;
        stall      = ~Imem_Ready;
        cnt_d      = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = StRun;
        end
      end
      StHalt: begin
        stall = 1'b1;
        if (Resume) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge Clk_Core or posedge Rst_Core) begin
    if (Rst_Core) begin
      state_q <= StRun;
      cnt_q   <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
    end
  end

  // Outputs are forced low while reset is held, even though requests may be active.
  assign PC_Sel            = pc_sel & ~Rst_Core;
  assign Stall             = stall & ~Rst_Core;
  assign Flush             = flush & ~Rst_Core;
  assign Flush_Pipe        = flush_pipe & ~Rst_Core;
  assign Program_Count_Imm = Rst_Core ? '0 : pc_imm;
  assign Halted            = (state_q == StHalt) & ~Rst_Core;
  assign Epc               = epc_q;

`ifdef PC_CTRL_PERF_EN
  logic [31:0] redirect_cnt_q, stall_cnt_q;

  always_ff @(posedge Clk_Core or posedge Rst_Core) begin
    if (Rst_Core) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (redirect && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign Redirect_Cnt = redirect_cnt_q;
  assign Stall_Cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: three instances (FLUSH_CYCLES 2, 1, 7) driven in lockstep
// and compared every cycle against a behavioural model, plus directed scenario checks.
module tb_pc_redirect_ctrl;

  localparam int unsigned NInst   = 3;
  localparam logic [31:0] TrapVec = 32'h0000_0100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        trap, mret, br, halt, resume, luh, imem;
  logic [31:0] trap_pc, br_tgt;

  logic        o_ps[NInst], o_st[NInst], o_fl[NInst], o_fp[NInst], o_hl[NInst];
  logic [31:0] o_imm[NInst], o_epc[NInst];
`ifdef PC_CTRL_PERF_EN
  logic [31:0] o_rc[NInst], o_sc[NInst];
`endif

  for (genvar g = 0; g < NInst; g++) begin : g_dut
    localparam int unsigned Fc = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
    pc_redirect_ctrl #(
      .DWIDTH      (32),
      .TRAP_VEC    (TrapVec),
      .FLUSH_CYCLES(Fc)
    ) u_dut (
      .Clk_Core         (clk),
      .Rst_Core         (rst),
      .Trap_Req         (trap),
      .Trap_Pc          (trap_pc),
      .Mret_Req         (mret),
      .Br_Taken         (br),
      .Br_Target        (br_tgt),
      .Halt_Req         (halt),
      .Resume           (resume),
      .Load_Use_Haz     (luh),
      .Imem_Ready       (imem),
      .PC_Sel           (o_ps[g]),
      .Stall            (o_st[g]),
      .Flush            (o_fl[g]),
      .Program_Count_Imm(o_imm[g]),
      .Flush_Pipe       (o_fp[g]),
      .Epc              (o_epc[g]),
      .Halted           (o_hl[g])
`ifdef PC_CTRL_PERF_EN
      ,
      .Redirect_Cnt     (o_rc[g]),
      .Stall_Cnt        (o_sc[g])
`endif
    );
  end

  int unsigned fc_tab[NInst] = '{2, 1, 7};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] z(input logic b);
    return {31'd0, b};
  endfunction

  // Model state: halted flag, remaining squash cycles, saved trap PC.
  bit          m_halt[NInst], n_halt[NInst];
  int          m_drain[NInst], n_drain[NInst];
  logic [31:0] m_epc[NInst], n_epc[NInst];
  logic [31:0] m_rc[NInst], n_rc[NInst], m_sc[NInst], n_sc[NInst];
  logic        e_ps[NInst], e_st[NInst], e_fl[NInst], e_fp[NInst], e_hl[NInst];
  logic [31:0] e_imm[NInst], e_epc[NInst];

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input bit inc);
    return (inc && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  task automatic model_eval(input int k);
    bit redir;
    redir    = 1'b0;
    e_ps[k]  = 1'b0;
    e_st[k]  = 1'b0;
    e_fl[k]  = 1'b0;
    e_fp[k]  = 1'b0;
    e_hl[k]  = 1'b0;
    e_imm[k] = '0;
    e_epc[k] = rst ? 32'd0 : m_epc[k];
    n_halt[k]  = m_halt[k];
    n_drain[k] = m_drain[k];
    n_epc[k]   = m_epc[k];
    if (rst) begin
      n_halt[k]  = 1'b0;
      n_drain[k] = 0;
      n_epc[k]   = '0;
    end else if (m_halt[k]) begin
      e_st[k] = 1'b1;
      e_hl[k] = 1'b1;
      if (resume) n_halt[k] = 1'b0;
    end else if (m_drain[k] > 0) begin
      e_fp[k]    = 1'b1;
      e_st[k]    = ~imem;
      n_drain[k] = m_drain[k] - 1;
    end else begin
      if (trap) begin
        e_fl[k] = 1'b1; e_imm[k] = TrapVec; n_epc[k] = trap_pc; redir = 1'b1;
      end else if (mret) begin
        e_fl[k] = 1'b1; e_imm[k] = m_epc[k]; redir = 1'b1;
      end else if (br) begin
        e_ps[k] = 1'b1; e_imm[k] = br_tgt; redir = 1'b1;
      end else if (halt) begin
        e_st[k] = 1'b1; n_halt[k] = 1'b1;
      end else begin
        e_st[k] = luh | ~imem;
      end
      if (redir) begin
        e_fp[k]    = 1'b1;
        n_drain[k] = int'(fc_tab[k]) - 1;
      end
    end
    n_rc[k] = rst ? 32'd0 : sat_inc(m_rc[k], redir);
    n_sc[k] = rst ? 32'd0 : sat_inc(m_sc[k], e_st[k]);
  endtask

  // Called at a negedge with inputs applied; compares, then advances one clock.
  task automatic run_cycle();
    #1;
    for (int k = 0; k < NInst; k++) begin
      model_eval(k);
      check($sformatf("pc_sel[%0d]", k), z(o_ps[k]), z(e_ps[k]));
      check($sformatf("stall[%0d]", k), z(o_st[k]), z(e_st[k]));
      check($sformatf("flush[%0d]", k), z(o_fl[k]), z(e_fl[k]));
      check($sformatf("flush_pipe[%0d]", k), z(o_fp[k]), z(e_fp[k]));
      check($sformatf("halted[%0d]", k), z(o_hl[k]), z(e_hl[k]));
      check($sformatf("pc_imm[%0d]", k), o_imm[k], e_imm[k]);
      check($sformatf("epc[%0d]", k), o_epc[k], e_epc[k]);
`ifdef PC_CTRL_PERF_EN
      check($sformatf("redirect_cnt[%0d]", k), o_rc[k], rst ? 32'd0 : m_rc[k]);
      check($sformatf("stall_cnt[%0d]", k), o_sc[k], rst ? 32'd0 : m_sc[k]);
`endif
    end
    @(posedge clk);
    for (int k = 0; k < NInst; k++) begin
      m_halt[k]  = n_halt[k];
      m_drain[k] = n_drain[k];
      m_epc[k]   = n_epc[k];
      m_rc[k]    = n_rc[k];
      m_sc[k]    = n_sc[k];
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 1'b0; trap = 1'b0; mret = 1'b0; br = 1'b0; halt = 1'b0; resume = 1'b0;
    luh = 1'b0; imem = 1'b1; trap_pc = '0; br_tgt = '0;
  endtask

  task automatic idle(input int n);
    set_idle();
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  int fp_cnt[NInst];

  initial begin
    for (int k = 0; k < NInst; k++) begin
      m_halt[k] = 1'b0; m_drain[k] = 0; m_epc[k] = '0; m_rc[k] = '0; m_sc[k] = '0;
    end
    // Reset with every request high: all outputs must be low.
    rst = 1'b1; trap = 1'b1; mret = 1'b1; br = 1'b1; halt = 1'b1; resume = 1'b1;
    luh = 1'b1; imem = 1'b0; trap_pc = 32'h1234; br_tgt = 32'h40;
    @(negedge clk);
    #1;
    for (int k = 0; k < NInst; k++) begin
      check("rst_outputs", {z(o_ps[k]) | z(o_st[k]) | z(o_fl[k]) | z(o_fp[k]) | z(o_hl[k])},
            32'd0);
      check("rst_pc_imm", o_imm[k], 32'd0);
      check("rst_epc", o_epc[k], 32'd0);
    end
    run_cycle();

    // Branch to 0x40, then a branch during the drain cycle must be ignored.
    set_idle(); br = 1'b1; br_tgt = 32'h40;
    #1;
    check("br_pc_sel", z(o_ps[0]), 32'd1);
    check("br_pc_imm", o_imm[0], 32'h40);
    check("br_flush_pipe", z(o_fp[0]), 32'd1);
    run_cycle();
    br = 1'b1; br_tgt = 32'h80;
    #1;
    check("drain_br_ignored", z(o_ps[0]), 32'd0);
    check("drain_flush_pipe", z(o_fp[0]), 32'd1);
    run_cycle();
    set_idle();
    #1;
    check("drain_done", z(o_fp[0]), 32'd0);
    run_cycle();
    idle(7);

    // Trap wins over mret and branch; Epc captured; later mret returns to it.
    trap = 1'b1; mret = 1'b1; br = 1'b1; trap_pc = 32'h1234; br_tgt = 32'h40;
    #1;
    check("trap_flush", z(o_fl[0]), 32'd1);
    check("trap_pc_sel", z(o_ps[0]), 32'd0);
    check("trap_vec", o_imm[0], 32'h100);
    run_cycle();
    set_idle();
    #1;
    check("epc_saved", o_epc[0], 32'h1234);
    idle(8);
    mret = 1'b1;
    #1;
    check("mret_flush", z(o_fl[0]), 32'd1);
    check("mret_target", o_imm[0], 32'h1234);
    run_cycle();
    idle(8);

    // Redirect overrides load-use stall; stall alone; imem stall during drain.
    luh = 1'b1; br = 1'b1; br_tgt = 32'h200;
    #1;
    check("luh_br_stall", z(o_st[0]), 32'd0);
    check("luh_br_pc_sel", z(o_ps[0]), 32'd1);
    run_cycle();
    idle(8);
    luh = 1'b1;
    #1;
    check("luh_stall", z(o_st[0]), 32'd1);
    run_cycle();
    set_idle(); br = 1'b1; br_tgt = 32'h300;
    run_cycle();
    set_idle(); imem = 1'b0;
    #1;
    check("drain_imem_stall", z(o_st[0]), 32'd1);
    check("drain_imem_fp", z(o_fp[0]), 32'd1);
    run_cycle();
    idle(8);

    // Halt, trap ignored while halted, resume.
    halt = 1'b1;
    #1;
    check("halt_req_stall", z(o_st[0]), 32'd1);
    check("halt_req_not_halted", z(o_hl[0]), 32'd0);
    run_cycle();
    set_idle(); trap = 1'b1; trap_pc = 32'hdead;
    #1;
    check("halted", z(o_hl[0]), 32'd1);
    check("halted_stall", z(o_st[0]), 32'd1);
    check("halted_trap_ignored", z(o_fl[0]), 32'd0);
    run_cycle();
    set_idle(); resume = 1'b1;
    run_cycle();
    set_idle();
    #1;
    check("resumed_stall", z(o_st[0]), 32'd0);
    check("resumed_halted", z(o_hl[0]), 32'd0);
    run_cycle();
    idle(8);

    // Flush_Pipe pulse length per FLUSH_CYCLES.
    for (int k = 0; k < NInst; k++) fp_cnt[k] = 0;
    br = 1'b1; br_tgt = 32'h44;
    for (int i = 0; i < 10; i++) begin
      #1;
      for (int k = 0; k < NInst; k++) fp_cnt[k] += int'(o_fp[k]);
      run_cycle();
      set_idle();
    end
    for (int k = 0; k < NInst; k++) check($sformatf("fp_len[%0d]", k), fp_cnt[k], fc_tab[k]);

    // Reset in drain cycle 3 of the 7-cycle instance drops Flush_Pipe immediately.
    br = 1'b1; br_tgt = 32'h48;
    run_cycle();
    idle(2);
    #1;
    check("drain3_fp_high", z(o_fp[2]), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_fp", z(o_fp[2]), 32'd0);
    run_cycle();
    idle(2);

`ifdef PC_CTRL_PERF_EN
    rst = 1'b1;
    run_cycle();
    for (int b = 0; b < 3; b++) begin
      set_idle(); br = 1'b1; br_tgt = 32'h500;
      run_cycle();
      idle(8);
    end
    for (int s = 0; s < 5; s++) begin
      set_idle(); luh = 1'b1;
      run_cycle();
    end
    set_idle();
    #1;
    check("perf_redirects", o_rc[0], 32'd3);
    check("perf_stalls", o_sc[0], 32'd5);
    run_cycle();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 63) == 0);
      trap    = ($urandom_range(0, 7) == 0);
      mret    = ($urandom_range(0, 7) == 0);
      br      = ($urandom_range(0, 3) == 0);
      halt    = ($urandom_range(0, 9) == 0);
      resume  = ($urandom_range(0, 3) == 0);
      luh     = ($urandom_range(0, 3) == 0);
      imem    = ($urandom_range(0, 3) != 0);
      trap_pc = $urandom;
      br_tgt  = $urandom;
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Control sequencer for the program counter: it arbitrates trap, return-from-trap, branch/jump and halt requests, plus load-use and instruction-memory stall sources, into the PC's `PC_Sel`/`Stall`/`Flush`/`Program_Count_Imm` controls. It also produces a pipeline flush pulse train that squashes wrong-path instructions, and holds the trap return address. It sits between the EX/hazard logic and the program counter in the RV32IM core.

## Interface
- `DWIDTH`, 32, address width
- `TRAP_VEC`, 32'h0000_0100, trap handler address
- `FLUSH_CYCLES`, 2, cycles `Flush_Pipe` is held per redirect; legal range 1..7

- `Clk_Core`  in  1  core clock
- `Rst_Core`  in  1  reset, asynchronous, active-high
- `Trap_Req`  in  1  exception/ecall request from EX
- `Trap_Pc`  in  DWIDTH  PC of the trapping instruction
- `Mret_Req`  in  1  return-from-trap request
- `Br_Taken`  in  1  resolved taken branch/jump from EX
- `Br_Target`  in  DWIDTH  branch/jump target
- `Halt_Req`  in  1  halt request (ebreak/debug)
- `Resume`  in  1  leave halt
- `Load_Use_Haz`  in  1  load-use hazard stall
- `Imem_Ready`  in  1  instruction memory can accept fetch
- `PC_Sel`  out  1  to PC: load `Program_Count_Imm` via mux
- `Stall`  out  1  to PC: hold
- `Flush`  out  1  to PC: forced load of `Program_Count_Imm`
- `Program_Count_Imm`  out  DWIDTH  redirect address
- `Flush_Pipe`  out  1  squash IF/ID and ID/EX registers
- `Epc`  out  DWIDTH  saved trap PC
- `Halted`  out  1  FSM in HALT

## Operation
- FSM states: RUN, DRAIN, HALT. Reset → RUN; drain counter = 0; `Epc` = 0.
- RUN, fixed priority:
  1. `Trap_Req`: `Flush`=1, `Program_Count_Imm`=`TRAP_VEC`, `Epc`←`Trap_Pc`.
  2. `Mret_Req`: `Flush`=1, `Program_Count_Imm`=`Epc`.
  3. `Br_Taken`: `PC_Sel`=1, `Program_Count_Imm`=`Br_Target`.
  4. `Halt_Req`: `Stall`=1; go to HALT.
  5. Otherwise `Stall` = `Load_Use_Haz | ~Imem_Ready`.
- Transitions on cases 1–3 (a redirect):
  - `Flush_Pipe`=1 and `Stall`=0 (a redirect overrides all stalls).
  - Next state is DRAIN with counter = `FLUSH_CYCLES`-1, or stays RUN if `FLUSH_CYCLES`=1.
- DRAIN:
  - `Flush_Pipe`=1.
  - All requests are ignored; they originate from squashed instructions.
  - `Stall` = `~Imem_Ready`.
  - Counter decrements each cycle; when it reaches 1, return to RUN.
- HALT:
  - `Stall`=1, `Halted`=1; `PC_Sel`, `Flush` and `Flush_Pipe` are 0.
  - Only `Resume` exits, to RUN. Other requests are ignored.
- Invariants:
  - `Stall` and `Flush`/`PC_Sel` are never asserted in the same cycle.
  - `Flush` and `PC_Sel` are mutually exclusive.
  - When no redirect is active, `Program_Count_Imm` = 0.

## Timing
- Redirect controls are combinational from the requests in RUN. The PC holds the target after the next `Clk_Core` rising edge, so redirect latency is 1 cycle.
- `Flush_Pipe` covers the redirect cycle plus `FLUSH_CYCLES`-1 DRAIN cycles.
- `Epc` updates on the edge ending the trap cycle. A same-cycle `Mret_Req` loses to `Trap_Req` and does not see the new `Epc`.
- HALT: entered on the edge after `Halt_Req`; `Halted` asserts the following cycle. `Resume` takes effect one edge later; the first RUN cycle evaluates requests normally.
- While `Rst_Core`=1, every output is 0 and the FSM is RUN. Asserting reset mid-DRAIN or mid-HALT aborts immediately.
- Reset deassertion is synchronized externally. The first edge after release is a normal RUN cycle.

## Configuration
- `PC_CTRL_PERF_EN` defined: adds two output ports, both reset to 0:
  - `Redirect_Cnt` (32-bit): increments once per accepted redirect; saturates at 32'hFFFF_FFFF.
  - `Stall_Cnt` (32-bit): increments on every cycle `Stall`=1, including HALT; saturates at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset with all requests high → all outputs 0. After release, with `Br_Taken`=1 and `Br_Target`=0x40: `PC_Sel`=1, `Program_Count_Imm`=0x40, `Flush_Pipe`=1 for 2 cycles, and `Br_Taken` is ignored in the DRAIN cycle.
- `Trap_Req`+`Mret_Req`+`Br_Taken` together with `Trap_Pc`=0x1234 → `Flush`=1 and `Program_Count_Imm`=0x100. Next cycle `Epc`=0x1234. A later `Mret_Req` → `Flush`=1 with `Program_Count_Imm`=0x1234.
- `Load_Use_Haz`=1 with `Br_Taken`=1 → `Stall`=0, `PC_Sel`=1. `Load_Use_Haz`=1 alone → `Stall`=1. `Imem_Ready`=0 during DRAIN → `Stall`=1 while `Flush_Pipe` stays 1.
- `Halt_Req` pulse → `Halted`=1 from the next cycle and `Stall` held. `Trap_Req` while halted is ignored. `Resume` → RUN with `Stall`=0 one cycle later.
- `FLUSH_CYCLES`=1 and `FLUSH_CYCLES`=7: `Flush_Pipe` is high for exactly 1 and 7 cycles respectively. Assert `Rst_Core` in DRAIN cycle 3 → `Flush_Pipe` drops asynchronously.
- With `PC_CTRL_PERF_EN`: 3 branches plus 5 stall cycles → `Redirect_Cnt`=3, `Stall_Cnt`=5. Preload near saturation and run 2 further branches → counter holds 0xFFFF_FFFF.
